// File: rtl/register_64_bit_loader.sv
// register_64_bit_loader: assembles eight handshaked bytes into one 64-bit register write.
// Define LOADER_VERIFY_EN to add a readback-and-compare after every write.
module register_64_bit_loader #(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [7:0]  byteIn,
   input  logic        byteValid,
   output logic        byteReady,
   input  logic        flush,
   output logic [63:0] regData,
   output logic        regE,
   output logic        regRW,
   input  logic [63:0] regDataOut,
   output logic [3:0]  byteCount,
   output logic        wordDone,
   output logic        verifyErr
);

   localparam int unsigned WORD_W    = 64;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned CNT_W     = 4;
   localparam int unsigned NUM_BYTES = WORD_W / BYTE_W;

   typedef enum logic [1:0] {
      COLLECT,
      WRITE
`ifdef LOADER_VERIFY_EN
      , READ,
      CHECK
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [WORD_W-1:0]   data_d;
   logic [CNT_W-1:0]    count_d;
   logic [2:0]          slot;
   logic                ready_d, e_d, rw_d, done_d;

   assign slot = byteCount[2:0];

   // Next state, byte assembly and next values of every registered output.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      data_d  = regData;
      count_d = byteCount;
      ready_d = 1'b0;
      e_d     = 1'b0;
      rw_d    = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         COLLECT: begin
            if (flush) begin
               count_d = '0;
               word_d  = '0;
            end else if (byteValid && byteReady) begin
               if (LSB_FIRST) word_d[{slot, 3'b000} +: BYTE_W] = byteIn;
               else           word_d[{~slot, 3'b000} +: BYTE_W] = byteIn;
               count_d = byteCount + CNT_W'(1);
               if (byteCount == CNT_W'(NUM_BYTES - 1)) begin
                  state_d = WRITE;
                  data_d  = word_d;
               end
            end
         end
`ifdef LOADER_VERIFY_EN
         WRITE: state_d = READ;
         READ:  state_d = CHECK;
         CHECK: begin
            state_d = COLLECT;
            count_d = '0;
         end
`else
         WRITE: begin
            state_d = COLLECT;
            count_d = '0;
         end
`endif
         default: state_d = COLLECT;
      endcase

      ready_d = (state_d == COLLECT);
      rw_d    = (state_d == WRITE);
`ifdef LOADER_VERIFY_EN
      e_d     = (state_d == WRITE) || (state_d == READ);
      done_d  = (state_d == CHECK);
`else
      e_d     = rw_d;
      done_d  = rw_d;
`endif
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q   <= COLLECT;
         word_q    <= '0;
         byteReady <= 1'b0;
         regData   <= '0;
         regE      <= 1'b0;
         regRW     <= 1'b0;
         byteCount <= '0;
         wordDone  <= 1'b0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         byteReady <= ready_d;
         regData   <= data_d;
         regE      <= e_d;
         regRW     <= rw_d;
         byteCount <= count_d;
         wordDone  <= done_d;
      end
   end

`ifdef LOADER_VERIFY_EN
   // Sticky flag: readback presented during CHECK must equal the word just written.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)                                        verifyErr <= 1'b0;
      else if ((state_q == CHECK) && (regDataOut != word_q)) verifyErr <= 1'b1;
   end
`else
   logic unused_readback;
   assign unused_readback = ^regDataOut;
   assign verifyErr       = 1'b0;
`endif

endmodule

// File: tb/tb_register_64_bit_loader.sv
// tb_register_64_bit_loader: scoreboard bench driving an LSB-first and an MSB-first loader in lockstep.
// Build with LOADER_VERIFY_EN defined to exercise the readback path.
module tb_register_64_bit_loader;

`ifdef LOADER_VERIFY_EN
   localparam int WORD_CYC = 11;
   localparam int DONE_LAT = 2;
   localparam int ABORTED  = 1;
`else
   localparam int WORD_CYC = 9;
   localparam int DONE_LAT = 0;
   localparam int ABORTED  = 0;
`endif

   logic        Clk, Rst_n;
   logic [7:0]  byteIn;
   logic        byteValid, flush;
   logic        byteReady_l, byteReady_m;
   logic [63:0] regData_l, regData_m, rdo_l, rdo_m;
   logic        regE_l, regE_m, regRW_l, regRW_m;
   logic [3:0]  byteCount_l, byteCount_m;
   logic        wordDone_l, wordDone_m, verifyErr_l, verifyErr_m;

   register_64_bit_loader #(.LSB_FIRST(1'b1)) dut_l (
      .Clk(Clk), .Rst_n(Rst_n), .byteIn(byteIn), .byteValid(byteValid), .byteReady(byteReady_l),
      .flush(flush), .regData(regData_l), .regE(regE_l), .regRW(regRW_l), .regDataOut(rdo_l),
      .byteCount(byteCount_l), .wordDone(wordDone_l), .verifyErr(verifyErr_l));

   register_64_bit_loader #(.LSB_FIRST(1'b0)) dut_m (
      .Clk(Clk), .Rst_n(Rst_n), .byteIn(byteIn), .byteValid(byteValid), .byteReady(byteReady_m),
      .flush(flush), .regData(regData_m), .regE(regE_m), .regRW(regRW_m), .regDataOut(rdo_m),
      .byteCount(byteCount_m), .wordDone(wordDone_m), .verifyErr(verifyErr_m));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Downstream 64-bit register models, one per loader.
   logic [63:0] mem_l = '0, mem_m = '0, dout_l = '0, dout_m = '0;
   logic        force_zero = 1'b0;
   always @(posedge Clk) begin
      if (regE_l) begin
         if (regRW_l) mem_l <= regData_l;
         else         dout_l <= mem_l;
      end
      if (regE_m) begin
         if (regRW_m) mem_m <= regData_m;
         else         dout_m <= mem_m;
      end
   end
   assign rdo_l = force_zero ? 64'h0 : dout_l;
   assign rdo_m = force_zero ? 64'h0 : dout_m;

   // Scoreboard model
   logic [63:0] exp_l[$], exp_m[$];
   logic [63:0] mdl_l = '0, mdl_m = '0;
   int          mdl_cnt = 0;
   int          n_words = 0;
   logic        exp_err = 1'b0;

   task automatic model_accept(input logic [7:0] b, output int cnt_after);
      mdl_l[mdl_cnt*8 +: 8]       = b;
      mdl_m[(7-mdl_cnt)*8 +: 8]   = b;
      mdl_cnt++;
      cnt_after = mdl_cnt;
      if (mdl_cnt == 8) begin
         exp_l.push_back(mdl_l);
         exp_m.push_back(mdl_m);
         n_words++;
         mdl_cnt = 0;
      end
   endtask

   // Called at a negedge; leaves byteValid high so callers can stream.
   task automatic send_byte(input logic [7:0] b);
      bit took = 0;
      int cnt_after = 0;
      byteIn    = b;
      byteValid = 1'b1;
      for (int n = 0; n < 64 && !took; n++) begin
         if (byteReady_l) begin
            took = 1;
            model_accept(b, cnt_after);
         end
         @(negedge Clk);
      end
      if (!took) check("accept_timeout", 64'd0, 64'd1);
      else begin
         check("byte_count_lsb", 64'(byteCount_l), 64'(cnt_after));
         check("byte_count_msb", 64'(byteCount_m), 64'(cnt_after));
      end
   endtask

   task automatic idle(input int n);
      byteValid = 1'b0;
      repeat (n) @(negedge Clk);
   endtask

   // Output monitor
   int cyc = 0;
   always @(posedge Clk) cyc++;

   int n_writes = 0, n_done = 0, last_wr = 0;
   int wr_cyc[$];
   bit done_prev = 0;
   always @(negedge Clk) begin
      if (Rst_n) begin
         if (regE_l && regRW_l) begin
            n_writes++;
            last_wr = cyc;
            wr_cyc.push_back(cyc);
            if (exp_l.size() == 0) check("write_unexpected", 64'd1, 64'd0);
            else begin
               check("reg_data_lsb", regData_l, exp_l.pop_front());
               check("reg_data_msb", regData_m, exp_m.pop_front());
               check("write_msb_strobe", 64'(regE_m & regRW_m), 64'd1);
            end
         end
         if (regE_l || wordDone_l) check("ready_busy", 64'(byteReady_l), 64'd0);
         if (wordDone_l) begin
            n_done++;
            check("done_latency", 64'(cyc - last_wr), 64'(DONE_LAT));
            if (done_prev) check("done_twice", 64'd1, 64'd0);
         end
         if (done_prev) begin
            check("verify_err_lsb", 64'(verifyErr_l), 64'(exp_err));
            check("verify_err_msb", 64'(verifyErr_m), 64'(exp_err));
         end
         done_prev = wordDone_l;
      end else done_prev = 0;
   end

   initial begin
      Rst_n = 1'b0; byteIn = '0; byteValid = 1'b0; flush = 1'b0;
      repeat (2) @(negedge Clk);
      check("rst_ready", 64'(byteReady_l), 64'd0);
      check("rst_e_rw",  64'({regE_l, regRW_l, regE_m, regRW_m}), 64'd0);
      check("rst_data",  regData_l | regData_m, 64'd0);
      check("rst_count", 64'(byteCount_l), 64'd0);
      check("rst_done_err", 64'({wordDone_l, verifyErr_l}), 64'd0);
      Rst_n = 1'b1;
      #1 check("ready_held_at_release", 64'(byteReady_l), 64'd0);
      @(negedge Clk);
      check("ready_after_release", 64'(byteReady_l), 64'd1);

      // Bytes 01..08 in order: both byte orders
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      idle(4);

      // Partial word flushed; the byte offered with flush must be dropped
      for (int i = 0; i < 3; i++) send_byte(8'(8'hE0 + i));
      flush = 1'b1; byteIn = 8'hAA; byteValid = 1'b1;
      @(negedge Clk);
      flush = 1'b0; byteValid = 1'b0;
      mdl_cnt = 0; mdl_l = '0; mdl_m = '0;
      check("flush_count_lsb", 64'(byteCount_l), 64'd0);
      check("flush_count_msb", 64'(byteCount_m), 64'd0);
      for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i));
      idle(4);

      // Two words back to back with byteValid held high
      for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + 3*i));
      byteValid = 1'b0;
      @(negedge Clk);
      if (wr_cyc.size() >= 2)
         check("word_period", 64'(wr_cyc[wr_cyc.size()-1] - wr_cyc[wr_cyc.size()-2]), 64'(WORD_CYC));
      else check("word_period_missing", 64'(wr_cyc.size()), 64'd2);
      idle(4);

`ifdef LOADER_VERIFY_EN
      // Forced readback of zero against a nonzero word, then a matching word
      force_zero = 1'b1;
      exp_err    = 1'b1;
      send_byte(8'h4B);
      for (int i = 0; i < 7; i++) send_byte(8'h00);
      idle(6);
      force_zero = 1'b0;
      for (int i = 0; i < 8; i++) send_byte(8'(8'h50 + i));
      idle(6);
      check("verify_err_sticky", 64'(verifyErr_l), 64'd1);
`else
      check("verify_err_tied", 64'({verifyErr_l, verifyErr_m}), 64'd0);
`endif

      // Reset asserted during the WRITE cycle
      for (int i = 0; i < 8; i++) send_byte(8'(8'hC0 + i));
      byteValid = 1'b0;
      #2 Rst_n = 1'b0;
      exp_err = 1'b0;
      mdl_cnt = 0;
      #1;
      check("arst_e_rw",   64'({regE_l, regRW_l, regE_m, regRW_m}), 64'd0);
      check("arst_data",   regData_l | regData_m, 64'd0);
      check("arst_count",  64'({byteCount_l, byteCount_m}), 64'd0);
      check("arst_done",   64'({wordDone_l, wordDone_m, verifyErr_l}), 64'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      #1 check("arst_ready_low", 64'(byteReady_l), 64'd0);
      @(negedge Clk);
      check("arst_ready_resume", 64'(byteReady_l), 64'd1);
      for (int i = 0; i < 8; i++) send_byte(8'(8'h90 - i));
      idle(6);

      check("scoreboard_empty", 64'(exp_l.size()), 64'd0);
      check("write_count", 64'(n_writes), 64'(n_words));
      check("done_count", 64'(n_done), 64'(n_words - ABORTED));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/register_64_bit_loader.md
# register_64_bit_loader

Byte-serial front end for the 64-bit register: accepts bytes over a valid/ready handshake, assembles them into one 64-bit word and issues a single write cycle (E/RW/dataIn) to the downstream 64-bit register. With the verify feature enabled it then reads the register back and flags any mismatch. It sits directly upstream of the 64-bit register and owns that register's E, RW and dataIn pins.

## Interface
- `LSB_FIRST`, 1: 1 = first accepted byte lands in bits [7:0]; 0 = first byte lands in bits [63:56].
- `Clk` input 1: single clock, all state changes on the rising edge.
- `Rst_n` input 1: asynchronous, active-low reset.
- `byteIn` input 8: data byte from the producer.
- `byteValid` input 1: producer has a byte on `byteIn`.
- `byteReady` output 1: loader can accept a byte this cycle.
- `flush` input 1: synchronous discard of any partially assembled word.
- `regData` output 64: drives the register's dataIn.
- `regE` output 1: drives the register's E.
- `regRW` output 1: drives the register's RW (1 = write, 0 = read).
- `regDataOut` input 64: register's dataOut. Used only with `LOADER_VERIFY_EN`.
- `byteCount` output 4: bytes held in the current partial word (0..8).
- `wordDone` output 1: one-cycle pulse when a word transaction completes.
- `verifyErr` output 1: sticky readback-mismatch flag. Constant 0 without `LOADER_VERIFY_EN`.

## Operation
- State register states: COLLECT, WRITE, READ*, CHECK* (* exists only with `LOADER_VERIFY_EN`).
- COLLECT:
  - `byteReady` = 1.
  - A byte is accepted on a rising edge with `byteValid && byteReady`.
  - The byte is stored in slot `byteCount`, placed per `LSB_FIRST`, and `byteCount` increments.
  - Accepting the 8th byte moves to WRITE and sets `byteCount` to 8.
- WRITE:
  - `regE` = 1, `regRW` = 1, `regData` = the assembled word, `byteReady` = 0.
  - Lasts exactly one cycle.
  - Without verify: `wordDone` = 1 in this cycle, then `byteCount` → 0 and the state returns to COLLECT.
  - With verify: moves to READ.
- READ:
  - `regE` = 1, `regRW` = 0.
  - Lasts one cycle; the register presents its stored word on `regDataOut` after this edge.
- CHECK:
  - `regE` = 0.
  - Compares `regDataOut` with the held word; on inequality, `verifyErr` sets at the end of the cycle.
  - `wordDone` = 1 for this cycle, then `byteCount` → 0 and the state returns to COLLECT.
- `regE` = 0 in COLLECT.
- `regData` holds its last driven value outside WRITE and is not cleared on flush.
- `flush`:
  - In COLLECT: `byteCount` → 0 and the partial word is discarded; a byte offered in the same cycle is not accepted (flush wins).
  - In WRITE/READ/CHECK: ignored. An issued write always completes.
- `verifyErr` clears only on reset.
- Reset (asynchronous, any state, including mid-WRITE):
  - State → COLLECT.
  - `byteReady` = 0, `regE` = 0, `regRW` = 0, `regData` = 0, `byteCount` = 0, `wordDone` = 0, `verifyErr` = 0.
  - A partial word is lost.

## Timing
- `byteReady` is registered. It rises on the first `Clk` edge after `Rst_n` deasserts and falls on the edge that accepts the 8th byte.
- Peak throughput: 8 bytes + 1 write cycle = 9 cycles per word without verify; 11 cycles with verify.
- Write latency: `regE`/`regRW` are high in the cycle immediately after the 8th-byte accept edge; the register captures the word on the next edge.
- `wordDone` is never high for two consecutive cycles.
- `byteValid` may be held high continuously. Bytes stall, and are not dropped, while `byteReady` = 0.

## Configuration
- `LOADER_VERIFY_EN` defined:
  - READ and CHECK states are compiled in.
  - Every write is followed by a readback and compare.
  - `verifyErr` is live.
- Not defined:
  - Only COLLECT and WRITE exist.
  - `regDataOut` is unused.
  - `verifyErr` is tied to 0.
  - `wordDone` asserts in the WRITE cycle.

## Test plan
- Reset, then send bytes 0x01..0x08 with `LSB_FIRST`=1 → one WRITE cycle with `regData` = 0x0807060504030201, `regE`=1, `regRW`=1, and `wordDone` pulsed once.
- Same bytes with `LSB_FIRST`=0 → `regData` = 0x0102030405060708.
- Send 3 bytes, then pulse `flush` together with a valid byte 0xAA → `byteCount` = 0 and 0xAA is not accepted; then 8 more bytes 0x10..0x17 → written word contains only 0x10..0x17.
- `byteValid` held high across two words → `byteReady` low during WRITE (and READ/CHECK); no bytes dropped or duplicated; second word correct; 9 (or 11) cycles per word.
- `LOADER_VERIFY_EN` with the bench forcing `regDataOut` = 0 against a written word of 0x0000_0000_0000_004B → `verifyErr` = 1 after CHECK and stays 1 through the next matching word.
- Assert `Rst_n` low during the WRITE cycle → `regE`, `regRW`, `regData`, `byteCount` and `wordDone` are 0 immediately (asynchronously); the loader resumes in COLLECT with `byteReady` = 1 one edge after release.
